// File: rtl/mem_arbiter_if.sv
// Bundles the two requester ports, the memory port and the status outputs of
// mem_arbiter; master is the arbiter's view, slave is the surrounding system's.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    logic              req0_enable_i;
    logic              req0_write_i;
    logic [ADDR_W-1:0] req0_addr_i;
    logic [LINE_W-1:0] req0_data_i;
    logic              req0_ack_o;

    logic              req1_enable_i;
    logic              req1_write_i;
    logic [ADDR_W-1:0] req1_addr_i;
    logic [LINE_W-1:0] req1_data_i;
    logic              req1_ack_o;

    logic [LINE_W-1:0] req_data_o;

    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [LINE_W-1:0] mem_data_o;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_i;

    logic [1:0]        grant_o;
    logic              err_o;

    modport master (
        input  req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
        input  req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
        input  mem_ack_i, mem_data_i,
        output req0_ack_o, req1_ack_o, req_data_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output grant_o, err_o
    );

    modport slave (
        output req0_enable_i, req0_write_i, req0_addr_i, req0_data_i,
        output req1_enable_i, req1_write_i, req1_addr_i, req1_data_i,
        output mem_ack_i, mem_data_i,
        input  req0_ack_o, req1_ack_o, req_data_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  grant_o, err_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-side
// (requester 0) and D-side (requester 1), with a busy watchdog and sticky error.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 256,
    parameter int TIMEOUT = 63
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mem_arbiter_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        GAP
    } state_e;

    localparam logic [6:0] CNT_LAST = 7'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic              last_q, last_d;      // 1 = requester 1 was served last
    logic [6:0]        cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    logic any_req;
    logic pick1;
    logic busy_ack;
    logic timeout;

    assign any_req  = bus.req0_enable_i | bus.req1_enable_i;
    assign pick1    = bus.req1_enable_i & (~bus.req0_enable_i | ~last_q);
    assign busy_ack = (state_q == BUSY) & bus.mem_ack_i;
    // A real ack on the final allowed cycle still completes normally.
    assign timeout  = (state_q == BUSY) & ~bus.mem_ack_i & (cnt_q == CNT_LAST);

    always_comb begin
        // NOTE: every _d gets its hold value first; a path that skipped one would infer a latch.
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        mem_en_d = mem_en_q;
        write_d  = write_q;
        addr_d   = addr_q;
        data_d   = data_q;
        err_d    = err_q;

        unique case (state_q)
            IDLE: begin
                err_d = err_q | bus.mem_ack_i;
                if (any_req) begin
                    state_d  = BUSY;
                    mem_en_d = 1'b1;
                    cnt_d    = '0;
                    grant_d  = pick1 ? 2'b10 : 2'b01;
                    write_d  = pick1 ? bus.req1_write_i : bus.req0_write_i;
                    addr_d   = pick1 ? bus.req1_addr_i  : bus.req0_addr_i;
                    data_d   = pick1 ? bus.req1_data_i  : bus.req0_data_i;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 7'd1;
                if (bus.mem_ack_i || timeout) begin
                    state_d  = GAP;
                    mem_en_d = 1'b0;
                    grant_d  = 2'b00;
                    last_d   = grant_q[1];
                    err_d    = err_q | timeout;
                end
            end
            GAP: begin
                state_d = IDLE;
                err_d   = err_q | bus.mem_ack_i;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking only here, so every flop samples pre-edge values regardless of order.
        if (rst_i) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= 1'b1;
            cnt_q    <= '0;
            mem_en_q <= 1'b0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            mem_en_q <= mem_en_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign bus.req0_ack_o   = busy_ack & grant_q[0];
    assign bus.req1_ack_o   = busy_ack & grant_q[1];
    assign bus.req_data_o   = busy_ack ? bus.mem_data_i : '0;
    assign bus.mem_enable_o = mem_en_q;
    assign bus.mem_write_o  = write_q;
    assign bus.mem_addr_o   = addr_q;
    assign bus.mem_data_o   = data_q;
    assign bus.grant_o      = grant_q;
    assign bus.err_o        = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized two-requester traffic.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 63;

    logic clk_i;
    logic rst_i;

    mem_arbiter_if #(.ADDR_W(AW), .LINE_W(LW)) bus ();

    mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] l;
        for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // ---------------- behavioural model ----------------
    bit            m_valid = 0;
    bit            m_busy, m_gap, m_err, m_write;
    int            m_owner, m_last, m_age;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_data;

    always @(posedge clk_i) begin
        if (rst_i) begin
            m_valid = 1; m_busy = 0; m_gap = 0; m_err = 0;
            m_owner = 0; m_last = 1; m_age = 0;
            m_write = 0; m_addr = '0; m_data = '0;
        end else if (m_valid) begin
            if (m_busy) begin
                m_age++;
                if (bus.mem_ack_i || m_age == TO) begin
                    if (!bus.mem_ack_i) m_err = 1;
                    m_last = m_owner;
                    m_busy = 0;
                    m_gap  = 1;
                end
            end else begin
                if (bus.mem_ack_i) m_err = 1;
                if (m_gap) m_gap = 0;
                else if (bus.req0_enable_i || bus.req1_enable_i) begin
                    if (bus.req0_enable_i && bus.req1_enable_i) m_owner = 1 - m_last;
                    else m_owner = bus.req0_enable_i ? 0 : 1;
                    m_write = m_owner ? bus.req1_write_i : bus.req0_write_i;
                    m_addr  = m_owner ? bus.req1_addr_i  : bus.req0_addr_i;
                    m_data  = m_owner ? bus.req1_data_i  : bus.req0_data_i;
                    m_busy  = 1;
                    m_age   = 0;
                end
            end
        end
    end

    always @(negedge clk_i) begin
        if (m_valid) begin
            logic e0, e1;
            e0 = m_busy && bus.mem_ack_i && m_owner == 0;
            e1 = m_busy && bus.mem_ack_i && m_owner == 1;
            check("grant", LW'(bus.grant_o), LW'(m_busy ? (m_owner ? 2'b10 : 2'b01) : 2'b00));
            check("mem_enable", LW'(bus.mem_enable_o), LW'(m_busy));
            check("mem_write", LW'(bus.mem_write_o), LW'(m_write));
            check("mem_addr", LW'(bus.mem_addr_o), LW'(m_addr));
            check("mem_data", bus.mem_data_o, m_data);
            check("req0_ack", LW'(bus.req0_ack_o), LW'(e0));
            check("req1_ack", LW'(bus.req1_ack_o), LW'(e1));
            check("req_data", bus.req_data_o, (e0 || e1) ? bus.mem_data_i : '0);
            check("err", LW'(bus.err_o), LW'(m_err));
        end
    end

    // ---------------- memory responder ----------------
    int            resp_mode = 0;   // 0 auto-ack, 1 silent, 2 manual
    bit            resp_rand = 0;
    int            resp_lat  = 10;
    logic [LW-1:0] resp_line = '0;
    logic          man_ack   = 1'b0;

    initial begin
        int busy_seen, cur_lat;
        busy_seen = 0; cur_lat = 1;
        bus.mem_ack_i  = 1'b0;
        bus.mem_data_i = '0;
        forever begin
            @(posedge clk_i);
            #2;
            bus.mem_data_i = rand_line();
            if (resp_mode == 2) begin
                bus.mem_ack_i = man_ack;
            end else if (bus.mem_enable_o) begin
                if (busy_seen == 0) cur_lat = resp_rand ? int'($urandom_range(1, 12)) : resp_lat;
                busy_seen++;
                if (resp_mode == 0 && busy_seen == cur_lat) begin
                    bus.mem_ack_i = 1'b1;
                    if (!resp_rand) bus.mem_data_i = resp_line;
                end else begin
                    bus.mem_ack_i = 1'b0;
                end
            end else begin
                busy_seen = 0;
                bus.mem_ack_i = 1'b0;
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    logic [1:0] gseq[$];

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        cyc();
        rst_i = 1'b1;
        bus.req0_enable_i = 1'b0;
        bus.req1_enable_i = 1'b0;
        cyc();
        cyc();
        rst_i = 1'b0;
    endtask

    // Waits for any requester ack; returns in the cycle after it (GAP).
    task automatic wait_any(input int budget, output int who, output int busy_n,
                            output int idle_n, output logic [LW-1:0] data);
        who = -1; busy_n = 0; idle_n = 0; data = '0;
        for (int c = 0; c < budget && who < 0; c++) begin
            @(negedge clk_i);
            if (gseq.size() == 0 || gseq[$] !== bus.grant_o) gseq.push_back(bus.grant_o);
            if (bus.mem_enable_o) busy_n++; else idle_n++;
            if (bus.req0_ack_o && bus.req1_ack_o) who = 2;
            else if (bus.req0_ack_o) who = 0;
            else if (bus.req1_ack_o) who = 1;
            if (who >= 0) data = bus.req_data_o;
            cyc();
        end
    endtask

    int            who, busy_n, idle_n, busy, dbad, stray, n_acks;
    bit            seen_low;
    logic          err_mid, err_after, a0, a1;
    logic [1:0]    g_low;
    logic [LW-1:0] line, got, a_line, b_line;

    initial begin
        rst_i = 1'b1;
        bus.req0_enable_i = 0; bus.req0_write_i = 0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
        bus.req1_enable_i = 0; bus.req1_write_i = 0; bus.req1_addr_i = '0; bus.req1_data_i = '0;
        cyc(); cyc(); cyc();
        rst_i = 1'b0;

        // reset state
        @(negedge clk_i);
        check("rst_grant", LW'(bus.grant_o), LW'(2'b00));
        check("rst_mem_enable", LW'(bus.mem_enable_o), '0);
        check("rst_mem_addr", LW'(bus.mem_addr_o), '0);
        check("rst_err", LW'(bus.err_o), '0);
        cyc();

        // single fill from requester 1, memory acks on its 10th busy cycle
        line = {2{128'h0123456789abcdef_fedcba9876543210}};
        resp_mode = 0; resp_rand = 0; resp_lat = 10; resp_line = line;
        bus.req1_enable_i = 1; bus.req1_write_i = 0; bus.req1_addr_i = 32'h0000_0200;
        bus.req1_data_i = rand_line();
        wait_any(60, who, busy_n, idle_n, got);
        bus.req1_enable_i = 0;
        check("fill_who", LW'(who), LW'(1));
        check("fill_busy_cycles", LW'(busy_n), LW'(10));
        check("fill_data", got, line);
        @(negedge clk_i);
        check("fill_gap_enable", LW'(bus.mem_enable_o), '0);
        check("fill_ack_pulse", LW'(bus.req1_ack_o), '0);
        check("fill_addr", LW'(bus.mem_addr_o), LW'(32'h200));

        // tie right after reset: 0 first, then 1 after GAP + one idle cycle
        do_reset();
        resp_lat = 3;
        gseq.delete();
        bus.req0_enable_i = 1; bus.req0_write_i = 0; bus.req0_addr_i = 32'h1000;
        bus.req1_enable_i = 1; bus.req1_write_i = 0; bus.req1_addr_i = 32'h2000;
        wait_any(40, who, busy_n, idle_n, got);
        bus.req0_enable_i = 0;
        check("tie_first", LW'(who), LW'(0));
        wait_any(40, who, busy_n, idle_n, got);
        bus.req1_enable_i = 0;
        check("tie_second", LW'(who), LW'(1));
        check("tie_idle_between", LW'(idle_n), LW'(2));
        check("tie_grant_seq", LW'({gseq[1], gseq[2], gseq[3]}), LW'(6'b01_00_10));

        // fairness with both held continuously
        do_reset();
        resp_rand = 1;
        bus.req0_enable_i = 1; bus.req1_enable_i = 1;
        for (int k = 0; k < 6; k++) begin
            wait_any(60, who, busy_n, idle_n, got);
            check($sformatf("fair_%0d", k), LW'(who), LW'(k % 2));
        end
        bus.req0_enable_i = 0; bus.req1_enable_i = 0;

        // write-back isolation: requester inputs change mid-BUSY
        do_reset();
        resp_rand = 0; resp_lat = 8;
        a_line = rand_line(); b_line = ~a_line;
        bus.req1_enable_i = 1; bus.req1_write_i = 1; bus.req1_addr_i = 32'h400; bus.req1_data_i = a_line;
        busy = 0; dbad = 0; stray = 0; who = -1;
        for (int c = 0; c < 40 && who < 0; c++) begin
            @(negedge clk_i);
            if (bus.mem_enable_o) begin
                busy++;
                if (bus.mem_data_o !== a_line || bus.mem_addr_o !== 32'h400 || bus.mem_write_o !== 1'b1) dbad++;
            end
            if (bus.req0_ack_o) stray++;
            if (bus.req1_ack_o) who = 1;
            cyc();
            if (busy == 3) begin
                bus.req1_data_i = b_line; bus.req1_addr_i = 32'h800; bus.req1_write_i = 0;
            end
        end
        bus.req1_enable_i = 0;
        check("wb_who", LW'(who), LW'(1));
        check("wb_busy_cycles", LW'(busy), LW'(8));
        check("wb_stable", LW'(dbad), '0);
        check("wb_no_req0_ack", LW'(stray), '0);

        // watchdog: memory never acks
        do_reset();
        resp_mode = 1;
        bus.req0_enable_i = 1; bus.req0_write_i = 0; bus.req0_addr_i = 32'h100;
        busy = 0; stray = 0; seen_low = 0; err_mid = 1'bx; err_after = 1'b0; g_low = 2'bxx;
        for (int c = 0; c < 120 && !seen_low; c++) begin
            @(negedge clk_i);
            if (bus.mem_enable_o) begin
                busy++;
                if (busy == TO - 1) err_mid = bus.err_o;
            end else if (busy > 0) begin
                seen_low = 1; err_after = bus.err_o; g_low = bus.grant_o;
            end
            if (bus.req0_ack_o || bus.req1_ack_o) stray++;
            cyc();
        end
        bus.req0_enable_i = 0;
        check("to_ended", LW'(seen_low), LW'(1));
        check("to_busy_cycles", LW'(busy), LW'(63));
        check("to_err_before", LW'(err_mid), '0);
        check("to_err_after", LW'(err_after), LW'(1));
        check("to_grant_gap", LW'(g_low), '0);
        check("to_no_ack", LW'(stray), '0);

        // spurious ack in IDLE
        do_reset();
        resp_mode = 2; man_ack = 0;
        @(negedge clk_i);
        check("sp_err_before", LW'(bus.err_o), '0);
        cyc();
        man_ack = 1;
        @(negedge clk_i);
        check("sp_acks", LW'({bus.req0_ack_o, bus.req1_ack_o}), '0);
        cyc();
        man_ack = 0;
        @(negedge clk_i);
        check("sp_err_set", LW'(bus.err_o), LW'(1));
        repeat (5) cyc();
        @(negedge clk_i);
        check("sp_err_sticky", LW'(bus.err_o), LW'(1));

        // reset during the 5th BUSY cycle, late memory ack afterwards
        do_reset();
        resp_mode = 0; resp_rand = 0; resp_lat = 30;
        bus.req1_enable_i = 1; bus.req1_write_i = 0; bus.req1_addr_i = 32'h300;
        busy = 0;
        for (int c = 0; c < 20 && busy < 4; c++) begin
            @(negedge clk_i);
            if (bus.mem_enable_o) busy++;
            cyc();
        end
        rst_i = 1; bus.req1_enable_i = 0;
        cyc();
        rst_i = 0;
        resp_mode = 2; man_ack = 0;
        @(negedge clk_i);
        check("rb_reached", LW'(busy), LW'(4));
        check("rb_enable", LW'(bus.mem_enable_o), '0);
        check("rb_grant", LW'(bus.grant_o), '0);
        check("rb_err_clear", LW'(bus.err_o), '0);
        repeat (4) cyc();
        man_ack = 1;
        @(negedge clk_i);
        check("rb_late_ack_routed", LW'({bus.req0_ack_o, bus.req1_ack_o}), '0);
        cyc();
        man_ack = 0;
        @(negedge clk_i);
        check("rb_late_ack_err", LW'(bus.err_o), LW'(1));

        // randomized traffic: requesters hold until acked, then may re-request
        do_reset();
        resp_mode = 0; resp_rand = 1;
        n_acks = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            a0 = bus.req0_ack_o; a1 = bus.req1_ack_o;
            n_acks += int'(a0) + int'(a1);
            cyc();
            if (!bus.req0_enable_i) bus.req0_enable_i = ($urandom_range(0, 2) == 0);
            else if (a0) bus.req0_enable_i = ($urandom_range(0, 1) == 1);
            if (!bus.req1_enable_i) bus.req1_enable_i = ($urandom_range(0, 2) == 0);
            else if (a1) bus.req1_enable_i = ($urandom_range(0, 1) == 1);
            bus.req0_write_i = ($urandom_range(0, 1) == 1);
            bus.req1_write_i = ($urandom_range(0, 1) == 1);
            bus.req0_addr_i  = $urandom;
            bus.req1_addr_i  = $urandom;
            bus.req0_data_i  = rand_line();
            bus.req1_data_i  = rand_line();
        end
        check("rand_traffic_flowed", LW'(n_acks > 50), LW'(1));
        bus.req0_enable_i = 0; bus.req1_enable_i = 0;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk_i and rst_i.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width.
REQ-003 Parameter LINE_W, default 256, SHALL set the cache-line data width.
REQ-004 Parameter TIMEOUT, default 63, SHALL set the maximum number of busy cycles before a watchdog error.
REQ-005 Ports SHALL be as follows, one per line:
  clk_i  in  1  clock
  rst_i  in  1  synchronous active-high reset
  req0_enable_i  in  1  requester 0 (I-side) line request
  req0_write_i  in  1  requester 0: 1=write-back, 0=fill
  req0_addr_i  in  ADDR_W  requester 0 line address
  req0_data_i  in  LINE_W  requester 0 write line
  req0_ack_o  out  1  requester 0 completion pulse
  req1_enable_i / req1_write_i / req1_addr_i / req1_data_i / req1_ack_o  same as req0, for requester 1 (dcache)
  req_data_o  out  LINE_W  fill data, valid only with an ack
  mem_enable_o  out  1  memory request
  mem_write_o  out  1  memory write
  mem_addr_o  out  ADDR_W  memory address
  mem_data_o  out  LINE_W  memory write line
  mem_ack_i  in  1  memory completion pulse
  mem_data_i  in  LINE_W  memory read line
  grant_o  out  2  one-hot current owner (00 when idle)
  err_o  out  1  sticky error: spurious ack or timeout

Function
REQ-006 States SHALL be IDLE, BUSY and GAP.
REQ-007 In IDLE, if any reqN_enable_i is high at a clock edge, the block SHALL move to BUSY on that edge, grant exactly one requester, and latch that requester's write, addr and data into capture registers.
REQ-008 Arbitration SHALL be round-robin: when both requesters are active, the one not granted last wins; a single active requester always wins.
REQ-009 mem_enable_o SHALL be 1 exactly while in BUSY; mem_write_o, mem_addr_o and mem_data_o SHALL come from the capture registers and stay stable for the whole of BUSY.
REQ-010 Changes on a requester's inputs during BUSY SHALL NOT affect the memory outputs.
REQ-011 While in BUSY with mem_ack_i=1, the block SHALL combinationally assert reqN_ack_o of the granted requester only and drive req_data_o = mem_data_i.
REQ-012 On the edge that samples that ack, the block SHALL go to GAP, update the last-grant record, and clear grant_o.
REQ-013 GAP SHALL last exactly 1 cycle with mem_enable_o=0, then the block SHALL return to IDLE, so there are at least 2 idle memory cycles between transactions.
REQ-014 A request still asserted after its ack SHALL be treated as a new request, arbitrated in IDLE.
REQ-015 A requester SHALL hold reqN_enable_i until its ack; a request dropped before grant is simply never served.
REQ-016 mem_ack_i=1 in IDLE or GAP SHALL be ignored for routing (no reqN_ack_o) and SHALL set err_o.
REQ-017 A 7-bit busy counter SHALL clear on entry to BUSY and increment each BUSY cycle.
REQ-018 When the counter reaches TIMEOUT, the block SHALL set err_o and force GAP with no ack to either requester.
REQ-019 err_o SHALL remain set until reset.
REQ-020 Outside REQ-011, reqN_ack_o SHALL be 0 and req_data_o SHALL be 0.

Reset
REQ-021 rst_i=1 at an edge SHALL force IDLE and set grant_o=00, mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0, ack outputs=0, err_o=0, busy counter=0, and last-grant=requester 1, so requester 0 wins the first tie.
REQ-022 Reset during BUSY SHALL abandon the transaction; no ack SHALL be issued for it, and a later mem_ack_i SHALL set err_o per REQ-016.

Verification
REQ-023 Single fill: req1 read at addr 0x0000_0200, memory model acks after 10 cycles with line 0x0123...3210 -> mem_enable_o high for 10 cycles with mem_addr_o=0x200 and mem_write_o=0; req1_ack_o is a 1-cycle pulse with req_data_o equal to the line; GAP is then 1 cycle.
REQ-024 Tie after reset: req0 and req1 raised in the same cycle -> req0 granted first, req1 granted on the cycle after GAP ends, grant_o sequence 01,00,10.
REQ-025 Fairness: both requesters held high continuously for 6 transactions -> grants alternate 0,1,0,1,0,1 and neither requester receives 2 consecutive grants.
REQ-026 Write-back isolation: req1 write to 0x400 with data A; req1_data_i changed to B mid-BUSY -> mem_data_o stays A until the ack, and no ack reaches req0.
REQ-027 Faults: memory never acks -> after 63 BUSY cycles err_o=1, GAP, no ack issued; separately, mem_ack_i pulsed in IDLE -> err_o=1 and both acks stay 0.
REQ-028 Reset mid-BUSY at cycle 5 of a fill -> next cycle mem_enable_o=0, grant_o=00, no ack; a memory ack arriving 5 cycles later sets err_o.
